hough_vote_sequencer: RTL and testbench
=======================================

Name: hough_vote_sequencer

Overview:
Controller that drives the accumulator-buffer datapath (theta/x/y input FIFOs → accumulator calc → row FIFO) for one frame. It pops edge pixels from an upstream pixel FIFO and issues one (theta, x, y) write per theta index into the datapath input FIFOs. In parallel it drains datapath results into a downstream vote FIFO, and it signals done once every issued triple has been drained. It sits between the edge-detect stage and the accumulator top.

Parameters:
THETAS, 180, number of theta indices issued per pixel (0..THETAS-1)
CNT_BITS, 32, width of the issued/drained/pixel counters

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at frame completion
pixel_empty  in  1  upstream pixel FIFO empty (show-ahead FIFO)
pixel_rd_en  out  1  pop upstream pixel FIFO
pixel_x  in  16  edge pixel x, valid when !pixel_empty
pixel_y  in  16  edge pixel y, valid when !pixel_empty
pixel_last  in  1  marks the final pixel of the frame
theta_in_full  in  1  datapath theta FIFO full
x_in_full  in  1  datapath x FIFO full
y_in_full  in  1  datapath y FIFO full
in_wr_en  out  1  shared write enable for the theta/x/y FIFOs
theta_din  out  16  theta index, zero-extended
data_in_x  out  16  latched pixel x
data_in_y  out  16  latched pixel y
row_out_empty  in  1  datapath row FIFO empty
row_out_rd_en  out  1  pop datapath row FIFO
row_out  in  16  datapath result word
vote_full  in  1  downstream vote FIFO full
vote_wr_en  out  1  write downstream vote FIFO
vote_dout  out  16  forwarded result word (= row_out)
pixel_count  out  CNT_BITS  pixels consumed this frame
vote_count  out  CNT_BITS  results drained this frame

Behaviour:
- States: IDLE, FETCH, ISSUE, FLUSH, DONE. Reset: state=IDLE; all counters, theta_idx, x_reg, y_reg, last_reg = 0; busy=0, done=0. All combinational outputs are 0 in IDLE.
- IDLE: on start → FETCH. On the same edge, issued_cnt, drained_cnt, pixel_count and vote_count clear to 0.
- FETCH:
  - pixel_rd_en = !pixel_empty.
  - On a pop: latch x_reg, y_reg, last_reg; theta_idx = 0; pixel_count++; → ISSUE.
  - If pixel_empty, wait in FETCH indefinitely.
- ISSUE:
  - in_wr_en = !(theta_in_full | x_in_full | y_in_full).
  - theta_din = theta_idx; data_in_x = x_reg; data_in_y = y_reg. These are stable while stalled.
  - On a write: issued_cnt++ and theta_idx++.
  - On the write with theta_idx == THETAS-1: → FLUSH if last_reg, else → FETCH.
  - Per-pixel cost is at least THETAS+1 cycles (one FETCH bubble).
- Drain, active in FETCH/ISSUE/FLUSH:
  - row_out_rd_en = vote_wr_en = !row_out_empty & !vote_full.
  - vote_dout = row_out, combinational.
  - Each transfer increments drained_cnt and vote_count. Inactive in IDLE/DONE.
- FLUSH: when the next-cycle drained_cnt equals issued_cnt → DONE. This includes a drain occurring in the current cycle.
- DONE: done=1 for exactly one cycle → IDLE. busy=1 in FETCH/ISSUE/FLUSH only.
- Result accounting: the datapath yields exactly one result word per issued triple.
- Counters wrap modulo 2^CNT_BITS; the equality compare still holds.
- start is ignored outside IDLE.
- Reset mid-frame returns to IDLE within one cycle with all state cleared. Datapath FIFOs share the same reset.
- Simultaneous issue and drain in one cycle is legal; both counters update.
- A frame must contain ≥1 pixel; pixel_last is only sampled on popped pixels.

Decomposition:
- Shared package hough_pkg:
  - state enum seq_state_t (IDLE, FETCH, ISSUE, FLUSH, DONE)
  - localparam DATA_W=16
  - function any_full() for the three full flags
- No sub-module is needed; a single always_ff plus always_comb FSM is sufficient.

Test Plan:
- THETAS=4, one pixel (x=10, y=20, last=1), no backpressure:
  - in_wr_en high 4 consecutive cycles with theta_din 0,1,2,3 and data_in_x=10, data_in_y=20.
  - After 4 row words are drained, done pulses once; pixel_count=1, vote_count=4.
- x_in_full forced high 3 cycles during theta_idx=2:
  - in_wr_en=0 for those 3 cycles; theta_din holds at 2.
  - Issue resumes with 2,3; total writes=4.
- Two pixels, pixel_empty high 5 cycles between them:
  - sequencer waits in FETCH; issued 8 triples total.
  - done only after drained=8 while the second pixel has last=1.
- vote_full high 10 cycles during FLUSH:
  - row_out_rd_en=0 and no done.
  - Drain completes after release; vote_dout matches row_out order exactly.
- start pulsed while busy: ignored, and counters are not cleared.
  - reset asserted mid-ISSUE: next cycle busy=0, in_wr_en=0, counters=0.
  - A new start then runs a full frame correctly.

Source files
------------

// File: rtl/hough_pkg.sv
// Shared types and helpers for the Hough vote sequencer.
package hough_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  function automatic logic any_full(input logic theta_full, input logic x_full,
                                    input logic y_full);
    return theta_full | x_full | y_full;
  endfunction

endpackage

// File: rtl/hough_vote_sequencer.sv
// Frame sequencer: pops edge pixels, issues THETAS (theta, x, y) triples per
// pixel into the accumulator datapath, and drains results into the vote FIFO.
module hough_vote_sequencer
  import hough_pkg::*;
#(
  parameter int THETAS   = 180,
  parameter int CNT_BITS = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                pixel_empty,
  output logic                pixel_rd_en,
  input  logic [DATA_W-1:0]   pixel_x,
  input  logic [DATA_W-1:0]   pixel_y,
  input  logic                pixel_last,
  input  logic                theta_in_full,
  input  logic                x_in_full,
  input  logic                y_in_full,
  output logic                in_wr_en,
  output logic [DATA_W-1:0]   theta_din,
  output logic [DATA_W-1:0]   data_in_x,
  output logic [DATA_W-1:0]   data_in_y,
  input  logic                row_out_empty,
  output logic                row_out_rd_en,
  input  logic [DATA_W-1:0]   row_out,
  input  logic                vote_full,
  output logic                vote_wr_en,
  output logic [DATA_W-1:0]   vote_dout,
  output logic [CNT_BITS-1:0] pixel_count,
  output logic [CNT_BITS-1:0] vote_count
);

  localparam logic [DATA_W-1:0] THETA_LAST = DATA_W'(THETAS - 1);

  seq_state_t          state_q, state_d;
  logic [DATA_W-1:0]   theta_idx_q, theta_idx_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                last_q, last_d;
  logic [CNT_BITS-1:0] issued_q, issued_d;
  logic [CNT_BITS-1:0] drained_q, drained_d;
  logic [CNT_BITS-1:0] pixel_count_q, pixel_count_d;
  logic [CNT_BITS-1:0] vote_count_q, vote_count_d;

  logic active;
  logic drain_go;
  logic issue_go;

  always_comb begin
    state_d       = state_q;
    theta_idx_d   = theta_idx_q;
    x_d           = x_q;
    y_d           = y_q;
    last_d        = last_q;
    issued_d      = issued_q;
    drained_d     = drained_q;
    pixel_count_d = pixel_count_q;
    vote_count_d  = vote_count_q;

    pixel_rd_en   = 1'b0;
    in_wr_en      = 1'b0;
    theta_din     = '0;
    data_in_x     = '0;
    data_in_y     = '0;
    issue_go      = 1'b0;

    active   = (state_q == FETCH) || (state_q == ISSUE) || (state_q == FLUSH);
    busy     = active;
    done     = (state_q == DONE);

    // Drain runs alongside fetch/issue so results never back up the datapath.
    drain_go      = active && !row_out_empty && !vote_full;
    row_out_rd_en = drain_go;
    vote_wr_en    = drain_go;
    vote_dout     = active ? row_out : '0;
    if (drain_go) begin
      drained_d    = drained_q + 1'b1;
      vote_count_d = vote_count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = FETCH;
          issued_d      = '0;
          drained_d     = '0;
          pixel_count_d = '0;
          vote_count_d  = '0;
        end
      end
      FETCH: begin
        pixel_rd_en = !pixel_empty;
        if (!pixel_empty) begin
          x_d           = pixel_x;
          y_d           = pixel_y;
          last_d        = pixel_last;
          theta_idx_d   = '0;
          pixel_count_d = pixel_count_q + 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        issue_go  = !any_full(theta_in_full, x_in_full, y_in_full);
        in_wr_en  = issue_go;
        theta_din = theta_idx_q;
        data_in_x = x_q;
        data_in_y = y_q;
        if (issue_go) begin
          issued_d    = issued_q + 1'b1;
          theta_idx_d = theta_idx_q + 1'b1;
          if (theta_idx_q == THETA_LAST) begin
            state_d = last_q ? FLUSH : FETCH;
          end
        end
      end
      FLUSH: begin
        // Compare against the post-drain count so a drain this cycle can finish.
        if (drained_d == issued_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    pixel_count = pixel_count_q;
    vote_count  = vote_count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      theta_idx_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      last_q        <= 1'b0;
      issued_q      <= '0;
      drained_q     <= '0;
      pixel_count_q <= '0;
      vote_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      theta_idx_q   <= theta_idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      last_q        <= last_d;
      issued_q      <= issued_d;
      drained_q     <= drained_d;
      pixel_count_q <= pixel_count_d;
      vote_count_q  <= vote_count_d;
    end
  end

endmodule

// File: tb/tb_hough_vote_sequencer.sv
// Directed bench for hough_vote_sequencer with THETAS=4, small pixel/row FIFO models.
module tb_hough_vote_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic        pixel_empty, pixel_rd_en;
  logic [15:0] pixel_x, pixel_y;
  logic        pixel_last;
  logic        theta_in_full = 1'b0;
  logic        x_in_full = 1'b0;
  logic        y_in_full = 1'b0;
  logic        in_wr_en;
  logic [15:0] theta_din, data_in_x, data_in_y;
  logic        row_out_empty, row_out_rd_en;
  logic [15:0] row_out;
  logic        vote_full = 1'b0;
  logic        vote_wr_en;
  logic [15:0] vote_dout;
  logic [31:0] pixel_count, vote_count;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  hough_vote_sequencer #(.THETAS(4), .CNT_BITS(32)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .pixel_empty(pixel_empty), .pixel_rd_en(pixel_rd_en),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_last(pixel_last),
    .theta_in_full(theta_in_full), .x_in_full(x_in_full), .y_in_full(y_in_full),
    .in_wr_en(in_wr_en), .theta_din(theta_din),
    .data_in_x(data_in_x), .data_in_y(data_in_y),
    .row_out_empty(row_out_empty), .row_out_rd_en(row_out_rd_en), .row_out(row_out),
    .vote_full(vote_full), .vote_wr_en(vote_wr_en), .vote_dout(vote_dout),
    .pixel_count(pixel_count), .vote_count(vote_count)
  );

  // Upstream pixel FIFO: entries appended by the stimulus, popped by the DUT.
  logic [15:0] px [16];
  logic [15:0] py [16];
  logic        pl [16];
  int          pix_n = 0;
  int          pidx  = 0;

  assign pixel_empty = (pidx >= pix_n);
  assign pixel_x     = px[pidx[3:0]];
  assign pixel_y     = py[pidx[3:0]];
  assign pixel_last  = pl[pidx[3:0]];

  always @(posedge clock) begin
    if (pixel_rd_en) pidx <= pidx + 1;
  end

  // Datapath stand-in: one result word per issued triple, word = {y[3:0], x[7:0], theta[3:0]}.
  logic [15:0] rmem [64];
  logic [5:0]  rwr = '0;
  logic [5:0]  rrd = '0;
  int          wr_cnt = 0;
  logic [15:0] got [64];
  int          got_n = 0;

  assign row_out_empty = (rwr == rrd);
  assign row_out       = rmem[rrd];

  always @(posedge clock) begin
    if (in_wr_en) wr_cnt <= wr_cnt + 1;
    if (vote_wr_en) begin
      got[got_n[5:0]] <= vote_dout;
      got_n <= got_n + 1;
    end
    if (reset) begin
      rwr <= '0;
      rrd <= '0;
    end else begin
      if (in_wr_en) begin
        rmem[rwr] <= {data_in_y[3:0], data_in_x[7:0], theta_din[3:0]};
        rwr <= rwr + 1'b1;
      end
      if (row_out_rd_en) rrd <= rrd + 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_pix(input logic [15:0] x, input logic [15:0] y, input logic l);
    px[pix_n[3:0]] = x;
    py[pix_n[3:0]] = y;
    pl[pix_n[3:0]] = l;
    pix_n++;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int target, input int bound);
    int n;
    n = 0;
    while (wr_cnt < target && n < bound) begin
      step();
      n++;
    end
    check({tag, "_writes_reached"}, 32'(wr_cnt), 32'(target));
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_words(input string tag, input int base, input logic [15:0] first);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_vote_word"}, 32'(got[(base + i) % 64]), 32'(first + 16'(i)));
    end
  endtask

  initial begin
    int base_w;
    int base_g;

    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_pixel_count", pixel_count, 32'd0);
    check("reset_vote_count", vote_count, 32'd0);
    reset = 1'b0;

    // Frame 1: single pixel, no backpressure; IDLE must ignore an available pixel.
    push_pix(16'd10, 16'd20, 1'b1);
    #1;
    check("idle_pixel_rd_en", 32'(pixel_rd_en), 32'd0);
    check("idle_in_wr_en", 32'(in_wr_en), 32'd0);
    base_g = got_n;
    do_start();
    check("f1_busy", 32'(busy), 32'd1);
    check("f1_pixel_rd_en", 32'(pixel_rd_en), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("f1_in_wr_en", 32'(in_wr_en), 32'd1);
      check("f1_theta", 32'(theta_din), 32'(i));
      check("f1_x", 32'(data_in_x), 32'd10);
      check("f1_y", 32'(data_in_y), 32'd20);
      step();
    end
    check("f1_flush_no_write", 32'(in_wr_en), 32'd0);
    wait_done("f1", 20);
    check("f1_pixel_count", pixel_count, 32'd1);
    check("f1_vote_count", vote_count, 32'd4);
    check_words("f1", base_g, 16'h40A0);

    // Frame 2: x FIFO full for 3 cycles at theta 2.
    push_pix(16'd30, 16'd40, 1'b1);
    base_w = wr_cnt;
    base_g = got_n;
    do_start();
    step();
    check("f2_theta0", 32'(theta_din), 32'd0);
    step();
    check("f2_theta1", 32'(theta_din), 32'd1);
    step();
    x_in_full = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("f2_stall_wr_en", 32'(in_wr_en), 32'd0);
      check("f2_stall_theta", 32'(theta_din), 32'd2);
      if (i < 2) step();
    end
    step();
    x_in_full = 1'b0;
    #1;
    check("f2_resume_wr_en", 32'(in_wr_en), 32'd1);
    check("f2_resume_theta2", 32'(theta_din), 32'd2);
    step();
    check("f2_resume_theta3", 32'(theta_din), 32'd3);
    wait_done("f2", 20);
    check("f2_total_writes", 32'(wr_cnt - base_w), 32'd4);
    check("f2_vote_count", vote_count, 32'd4);
    check_words("f2", base_g, 16'h81E0);

    // Frame 3: two pixels, upstream empty for 5 cycles between them.
    push_pix(16'd1, 16'd2, 1'b0);
    base_w = wr_cnt;
    do_start();
    wait_writes("f3a", base_w + 4, 20);
    for (int i = 0; i < 5; i++) begin
      check("f3_wait_rd_en", 32'(pixel_rd_en), 32'd0);
      check("f3_wait_busy", 32'(busy), 32'd1);
      check("f3_wait_done", 32'(done), 32'd0);
      step();
    end
    push_pix(16'd3, 16'd4, 1'b1);
    #1;
    check("f3_second_pop", 32'(pixel_rd_en), 32'd1);
    wait_done("f3", 30);
    check("f3_pixel_count", pixel_count, 32'd2);
    check("f3_vote_count", vote_count, 32'd8);
    check("f3_total_writes", 32'(wr_cnt - base_w), 32'd8);

    // Frame 4: vote FIFO full for 10 cycles while flushing.
    push_pix(16'd5, 16'd6, 1'b1);
    vote_full = 1'b1;
    base_w = wr_cnt;
    base_g = got_n;
    do_start();
    wait_writes("f4", base_w + 4, 20);
    for (int i = 0; i < 10; i++) begin
      check("f4_hold_rd_en", 32'(row_out_rd_en), 32'd0);
      check("f4_hold_done", 32'(done), 32'd0);
      step();
    end
    check("f4_hold_vote_count", vote_count, 32'd0);
    vote_full = 1'b0;
    #1;
    check("f4_release_rd_en", 32'(row_out_rd_en), 32'd1);
    check("f4_vote_dout", 32'(vote_dout), 32'h6050);
    wait_done("f4", 20);
    check("f4_vote_count", vote_count, 32'd4);
    check_words("f4", base_g, 16'h6050);

    // Frame 5: start while busy is ignored, then reset mid-issue.
    push_pix(16'd7, 16'd8, 1'b1);
    do_start();
    step();
    step();
    start = 1'b1;
    #1;
    check("f5_busy_start_theta", 32'(theta_din), 32'd1);
    step();
    start = 1'b0;
    #1;
    check("f5_no_restart_theta", 32'(theta_din), 32'd2);
    check("f5_no_clear_pixels", pixel_count, 32'd1);
    step();
    check("f5_no_clear_votes", vote_count, 32'd2);
    check("f5_mid_issue", 32'(in_wr_en), 32'd1);
    reset = 1'b1;
    step();
    check("f5_rst_busy", 32'(busy), 32'd0);
    check("f5_rst_in_wr_en", 32'(in_wr_en), 32'd0);
    check("f5_rst_pixel_count", pixel_count, 32'd0);
    check("f5_rst_vote_count", vote_count, 32'd0);
    reset = 1'b0;

    // Frame 6: full frame after the mid-frame reset.
    push_pix(16'd9, 16'd11, 1'b1);
    base_g = got_n;
    do_start();
    wait_done("f6", 30);
    check("f6_pixel_count", pixel_count, 32'd1);
    check("f6_vote_count", vote_count, 32'd4);
    check_words("f6", base_g, 16'hB090);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
